i2c_byte_sequencer: RTL

Byte-level sequencer that sits directly upstream of the universal shift-register functional unit in the I2C datapath. It accepts a one-byte transmit or receive command, and issues the unit's mode select, parallel data and serial-in so the register loads, then shifts MSB-first, one bit per bus bit strobe. It then handles the ninth (ACK) bit and returns the assembled byte and ACK status. The shift register is external: this block owns only control, bit counting and the ACK phase.

---
 rtl/i2c_byte_sequencer_pkg.sv | 25 ++
 rtl/i2c_byte_sequencer_if.sv | 32 +++
 rtl/i2c_byte_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/i2c_byte_sequencer_pkg.sv
// rtl/i2c_byte_sequencer_pkg.sv - shared I2C datapath types: shift-register modes, sequencer states, byte width
package i2c_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        FU_HOLD = 3'd0,
        FU_LOAD = 3'd1,
        FU_SHR  = 3'd2,
        FU_SHL  = 3'd3,
        FU_ROR  = 3'd4,
        FU_ROL  = 3'd5,
        FU_ASR  = 3'd6,
        FU_LSL  = 3'd7
    } fu_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/i2c_byte_sequencer_if.sv
// rtl/i2c_byte_sequencer_if.sv - command, bus-bit and shift-register signals of the byte sequencer
interface i2c_byte_sequencer_if #(parameter int N = 8);

    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_rx;
    logic [N-1:0] cmd_data;
    logic         cmd_nack;
    logic         abort;
    logic         bit_tick;
    logic         bit_in;
    logic         bit_out;
    logic [2:0]   fu_s;
    logic [N-1:0] fu_d;
    logic         fu_msb_in;
    logic         fu_lsb_in;
    logic [N-1:0] fu_q;
    logic         done;
    logic [N-1:0] rx_data;
    logic         ack_ok;

    modport master (
        output cmd_valid, cmd_rx, cmd_data, cmd_nack, abort, bit_tick, bit_in, fu_q,
        input  cmd_ready, bit_out, fu_s, fu_d, fu_msb_in, fu_lsb_in, done, rx_data, ack_ok
    );

    modport slave (
        input  cmd_valid, cmd_rx, cmd_data, cmd_nack, abort, bit_tick, bit_in, fu_q,
        output cmd_ready, bit_out, fu_s, fu_d, fu_msb_in, fu_lsb_in, done, rx_data, ack_ok
    );

endinterface

// File: rtl/i2c_byte_sequencer.sv
// rtl/i2c_byte_sequencer.sv - drives an external shift register through load, N MSB-first shifts and the ACK bit
module i2c_byte_sequencer
    import i2c_pkg::*;
#(
    parameter int N = BYTE_W
) (
    input  logic Clock,
    input  logic Clear,
    i2c_byte_sequencer_if.slave bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    seq_state_e    state, next_state;
    logic [CW-1:0] cnt;
    logic          rx_l;
    logic          nack_l;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.cmd_valid) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: if (bus.bit_tick && cnt == LAST) next_state = ST_ACK;
            ST_ACK:   if (bus.bit_tick) next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
        if (bus.abort) next_state = ST_IDLE;
    end

    always_comb begin
        bus.cmd_ready = (state == ST_IDLE);
        bus.fu_msb_in = 1'b0;
        bus.fu_lsb_in = bus.bit_in;
        bus.bit_out   = 1'b1;
        bus.fu_s      = FU_HOLD;
        case (state)
            ST_LOAD:  bus.fu_s = FU_LOAD;
            ST_SHIFT: begin
                bus.bit_out = rx_l ? 1'b1 : bus.fu_q[N-1];
                if (bus.bit_tick) bus.fu_s = FU_SHL;
            end
            ST_ACK:   bus.bit_out = rx_l ? nack_l : 1'b1;
            default:  ;
        endcase
        if (bus.abort) bus.fu_s = FU_HOLD;
    end

    // rx_data is taken on the ACK tick: the last SHL already landed and ACK holds the register
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            cnt         <= '0;
            rx_l        <= 1'b0;
            nack_l      <= 1'b0;
            bus.fu_d    <= '0;
            bus.done    <= 1'b0;
            bus.rx_data <= '0;
            bus.ack_ok  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: if (bus.cmd_valid && !bus.abort) begin
                    rx_l     <= bus.cmd_rx;
                    nack_l   <= bus.cmd_nack;
                    bus.fu_d <= bus.cmd_rx ? '0 : bus.cmd_data;
                end
                ST_LOAD: cnt <= '0;
                ST_SHIFT: if (bus.bit_tick && !bus.abort && cnt != LAST) cnt <= cnt + CW'(1);
                ST_ACK: if (bus.bit_tick && !bus.abort) begin
                    bus.ack_ok  <= rx_l ? ~nack_l : ~bus.bit_in;
                    bus.rx_data <= bus.fu_q;
                    bus.done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
